// File: rtl/iod_rx_lane_trainer.sv
// RX lane delay-line trainer: sweeps every tap of each lane in turn, tracks
// the widest passing window reported by the pattern checker, then parks the
// lane at the centre of that window. Every delay-line change is wrapped in
// an HS_IO_CLK_PAUSE window (one pre cycle, the pulse, PAUSE_EXT post cycles).
module iod_rx_lane_trainer #(
  parameter int NUM_LANES     = 4,
  parameter int TAP_BITS      = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int PAUSE_EXT     = 3,
  parameter int MIN_EYE       = 4
) (
  input  logic                              FAB_CLK,
  input  logic                              RESET_N,
  input  logic                              START,
  input  logic                              ALIGN_VALID,
  input  logic [NUM_LANES-1:0]              ALIGN_OK,
  input  logic [NUM_LANES-1:0]              DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]              DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]              DELAY_LINE_MOVE,
  output logic                              DELAY_LINE_DIRECTION,
  output logic                              HS_IO_CLK_PAUSE,
  output logic                              BUSY,
  output logic                              DONE,
  output logic [NUM_LANES-1:0]              LANE_FAIL,
  output logic [NUM_LANES*TAP_BITS-1:0]     LANE_TAP,
  output logic [NUM_LANES*(TAP_BITS+1)-1:0] LANE_EYE
);

  localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int EW       = TAP_BITS + 1;
  // Pulse sequence phases: 0 = pre, 1 = pulse, 2..SEQ_LAST = post extension
  localparam int SEQ_LAST = PAUSE_EXT + 1;
  localparam int SW       = $clog2(SEQ_LAST + 1);
  localparam int CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, SWEEP_LOAD, SETTLE, SAMPLE, SWEEP_STEP,
    CALC, PARK_LOAD, PARK_STEP, NEXT, FINISH
  } state_t;

  state_t                          state_q, state_d;
  logic [LW-1:0]                   lane_q, lane_d;
  logic [TAP_BITS-1:0]             tap_q, tap_d;
  logic [SW-1:0]                   seq_q, seq_d;
  logic                            armed_q, armed_d;
  logic [CW-1:0]                   settle_q, settle_d;
  logic [EW-1:0]                   run_len_q, run_len_d;
  logic [TAP_BITS-1:0]             run_start_q, run_start_d;
  logic [EW-1:0]                   best_len_q, best_len_d;
  logic [TAP_BITS-1:0]             best_start_q, best_start_d;
  logic [TAP_BITS-1:0]             target_q, target_d;
  logic [NUM_LANES-1:0]            fail_q, fail_d;
  logic [NUM_LANES*TAP_BITS-1:0]   ltap_q, ltap_d;
  logic [NUM_LANES*EW-1:0]         leye_q, leye_d;

  logic [NUM_LANES-1:0]            load_c, move_c;
  logic                            pause_c, done_c;
  logic                            seq_pulse, seq_last;
  logic [EW-1:0]                   run_nxt;
  logic [TAP_BITS-1:0]             start_w;

  // Centre of the window, rounded down; the sum never exceeds the last passing tap.
  function automatic logic [TAP_BITS-1:0] park_target(input logic [TAP_BITS-1:0] start,
                                                      input logic [EW-1:0]       len);
    logic [EW-1:0] sum;
    sum = {1'b0, start} + (len >> 1);
    return sum[TAP_BITS-1:0];
  endfunction

  assign seq_pulse = (seq_q == SW'(1));
  assign seq_last  = (seq_q == SW'(SEQ_LAST));

  // Next-state, pulse sequencing, window tracking and result capture.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    seq_d        = seq_q;
    armed_d      = armed_q;
    settle_d     = settle_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    target_d     = target_q;
    fail_d       = fail_q;
    ltap_d       = ltap_q;
    leye_d       = leye_q;
    load_c       = '0;
    move_c       = '0;
    pause_c      = 1'b0;
    done_c       = 1'b0;
    run_nxt      = '0;
    start_w      = tap_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          fail_d  = '0;
          ltap_d  = '0;
          leye_d  = '0;
          lane_d  = '0;
          seq_d   = '0;
          armed_d = 1'b0;
          state_d = SWEEP_LOAD;
        end
      end

      SWEEP_LOAD, PARK_LOAD: begin
        pause_c = 1'b1;
        if (seq_pulse) begin
          load_c[lane_q] = 1'b1;
          tap_d          = '0;
        end
        if (state_q == SWEEP_LOAD) begin
          run_len_d    = '0;
          run_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
        end
        if (seq_last) begin
          seq_d   = '0;
          state_d = (state_q == SWEEP_LOAD) ? SETTLE : PARK_STEP;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end

      SETTLE: begin
        if (settle_q == CW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      SAMPLE: begin
        if (ALIGN_VALID) begin
          if (ALIGN_OK[lane_q]) begin
            run_nxt = run_len_q + 1'b1;
            start_w = (run_len_q == '0) ? tap_q : run_start_q;
          end
          run_len_d   = run_nxt;
          run_start_d = start_w;
          if (run_nxt > best_len_q) begin
            best_len_d   = run_nxt;
            best_start_d = start_w;
          end
          state_d = SWEEP_STEP;
        end
      end

      // Decision cycle (PAUSE low) first, then the MOVE pulse sequence.
      SWEEP_STEP: begin
        if (!armed_q) begin
          if (tap_q == TAP_MAX || DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            state_d = CALC;
          end else begin
            armed_d = 1'b1;
          end
        end else begin
          pause_c = 1'b1;
          if (seq_pulse) begin
            move_c[lane_q] = 1'b1;
            tap_d          = tap_q + 1'b1;
          end
          if (seq_last) begin
            seq_d   = '0;
            armed_d = 1'b0;
            state_d = SETTLE;
          end else begin
            seq_d = seq_q + 1'b1;
          end
        end
      end

      CALC: begin
        leye_d[int'(lane_q)*EW +: EW] = best_len_q;
        if (best_len_q >= EW'(MIN_EYE)) begin
          target_d = park_target(best_start_q, best_len_q);
        end else begin
          target_d       = '0;
          fail_d[lane_q] = 1'b1;
        end
        seq_d   = '0;
        state_d = PARK_LOAD;
      end

      PARK_STEP: begin
        if (!armed_q) begin
          if (tap_q == target_q) begin
            ltap_d[int'(lane_q)*TAP_BITS +: TAP_BITS] = target_q;
            state_d = NEXT;
          end else begin
            armed_d = 1'b1;
          end
        end else begin
          pause_c = 1'b1;
          if (seq_pulse) begin
            move_c[lane_q] = 1'b1;
            tap_d          = tap_q + 1'b1;
          end
          if (seq_last) begin
            seq_d   = '0;
            armed_d = 1'b0;
          end else begin
            seq_d = seq_q + 1'b1;
          end
        end
      end

      NEXT: begin
        if (lane_q == LW'(NUM_LANES - 1)) begin
          state_d = FINISH;
        end else begin
          lane_d  = lane_q + 1'b1;
          seq_d   = '0;
          state_d = SWEEP_LOAD;
        end
      end

      FINISH: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any training in progress.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      seq_q        <= '0;
      armed_q      <= 1'b0;
      settle_q     <= '0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      target_q     <= '0;
      fail_q       <= '0;
      ltap_q       <= '0;
      leye_q       <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      seq_q        <= seq_d;
      armed_q      <= armed_d;
      settle_q     <= settle_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      target_q     <= target_d;
      fail_q       <= fail_d;
      ltap_q       <= ltap_d;
      leye_q       <= leye_d;
    end
  end

  assign DELAY_LINE_LOAD      = load_c;
  assign DELAY_LINE_MOVE      = move_c;
  assign DELAY_LINE_DIRECTION = 1'b1;
  assign HS_IO_CLK_PAUSE      = pause_c;
  assign BUSY                 = (state_q != IDLE) && (state_q != FINISH);
  assign DONE                 = done_c;
  assign LANE_FAIL            = fail_q;
  assign LANE_TAP             = ltap_q;
  assign LANE_EYE             = leye_q;

endmodule
